pipelined_parallel_adder: RTL



---
 rtl/pipelined_parallel_adder.sv | 92 +++++++++
 1 files changed

// File: rtl/pipelined_parallel_adder.sv
// Add/subtract of two WIDTH-bit operands with the carry chain cut into STAGES registered chunks.
// One operation per cycle under a valid/ready handshake; carry/borrow-out and signed overflow.
module pipelined_parallel_adder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW  = WIDTH / STAGES;
  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH-1:0] y_cond;
  logic             c0;
  logic             en;

  // Per-stage state: x_q/y_q carry the not-yet-summed upper chunks (y already conditioned),
  // sum_q accumulates the finished lower chunks so every chunk of one op leaves together.
  logic [WIDTH-1:0] x_q     [STAGES];
  logic [WIDTH-1:0] y_q     [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic             carry_q [STAGES];
  logic             sub_q   [STAGES];
  logic             valid_q [STAGES];

  logic [CW:0]      part    [STAGES];

  always_comb begin
    y_cond  = sub ? ~y : y;
    c0      = sub ? ~cin : cin;
    part[0] = {1'b0, x[CW-1:0]} + {1'b0, y_cond[CW-1:0]} + {{CW{1'b0}}, c0};
    for (int k = 1; k < STAGES; k++) begin
      part[k] = {1'b0, x_q[k-1][k*CW +: CW]} + {1'b0, y_q[k-1][k*CW +: CW]}
              + {{CW{1'b0}}, carry_q[k-1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        x_q[k]     <= '0;
        y_q[k]     <= '0;
        sum_q[k]   <= '0;
        carry_q[k] <= 1'b0;
        sub_q[k]   <= 1'b0;
        valid_q[k] <= 1'b0;
      end
    end else if (en) begin
      valid_q[0] <= in_valid;
      // Data only loads behind a valid op, so the output holds its last result through bubbles.
      if (in_valid) begin
        x_q[0]     <= x;
        y_q[0]     <= y_cond;
        sub_q[0]   <= sub;
        carry_q[0] <= part[0][CW];
        sum_q[0]   <= WIDTH'(part[0][CW-1:0]);
      end
      for (int k = 1; k < STAGES; k++) begin
        valid_q[k] <= valid_q[k-1];
        if (valid_q[k-1]) begin
          x_q[k]                 <= x_q[k-1];
          y_q[k]                 <= y_q[k-1];
          sub_q[k]               <= sub_q[k-1];
          carry_q[k]             <= part[k][CW];
          sum_q[k]               <= sum_q[k-1];
          sum_q[k][k*CW +: CW]   <= part[k][CW-1:0];
        end
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out       = sum_q[STAGES-1];
  assign cout      = sub_q[STAGES-1] ^ carry_q[STAGES-1];
  assign ovf       = (x_q[STAGES-1][MSB] == y_q[STAGES-1][MSB]) &&
                     (out[MSB] != x_q[STAGES-1][MSB]);
  assign en        = out_ready || !out_valid;
  assign in_ready  = en;

endmodule
